// File: rtl/des_pkg.sv
// Shared definitions for the DES block packer datapath.
package des_pkg;

  // Bytes per DES block. The packer supports only this value.
  localparam int unsigned BLOCK_BYTES = 8;

  // Packer states: FILL collects bytes, and HOLD presents a finished block.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/des_block_packer_flex_counter.sv
// Free-running up counter with enable. It wraps modulo 2^WIDTH.
module flex_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             count_enable,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] cnt_q;

  // Count one step per enabled cycle. Overflow wraps naturally.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (count_enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count_out = cnt_q;

endmodule

// File: rtl/des_block_packer.sv
// Packs a byte stream into 64-bit DES blocks, MSB-first.
// A short final block is padded PKCS#5-style.
module des_block_packer #(
  parameter int unsigned BLOCK_BYTES = des_pkg::BLOCK_BYTES
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  input  logic        rx_last,
  output logic        rx_byte_ready,
  output logic [63:0] rcv_data,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        blk_last,
  output logic [2:0]  pad_count,
  output logic [15:0] blk_count
);

  import des_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(BLOCK_BYTES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [63:0] fill_data;
  logic        accept;
  logic        handoff;

  assign accept  = (state == FILL) && rx_byte_valid && rx_byte_ready;
  assign handoff = (state == HOLD) && blk_ready;

  // Next block contents: the incoming byte goes at idx. On a short final byte,
  // every later slot gets the pad value, so the block is complete in one cycle.
  always_comb begin
    fill_data = rcv_data;
    fill_data[63 - 8*idx -: 8] = rx_byte;
    if (rx_last) begin
      for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
        if (i > 32'(idx)) begin
          fill_data[63 - 8*i -: 8] = {5'd0, LAST_IDX - idx};
        end
      end
    end
  end

  // FILL/HOLD control, with registered handshake and block outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= FILL;
      idx           <= '0;
      rcv_data      <= '0;
      blk_valid     <= 1'b0;
      blk_last      <= 1'b0;
      pad_count     <= '0;
      rx_byte_ready <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            rcv_data <= fill_data;
            if (idx == LAST_IDX) begin
              state         <= HOLD;
              blk_valid     <= 1'b1;
              rx_byte_ready <= 1'b0;
              blk_last      <= rx_last;
              pad_count     <= '0;
              idx           <= '0;
            end else if (rx_last) begin
              state         <= HOLD;
              blk_valid     <= 1'b1;
              rx_byte_ready <= 1'b0;
              blk_last      <= 1'b1;
              pad_count     <= LAST_IDX - idx;
              idx           <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (blk_ready) begin
            state         <= FILL;
            blk_valid     <= 1'b0;
            blk_last      <= 1'b0;
            pad_count     <= '0;
            idx           <= '0;
            rx_byte_ready <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  flex_counter #(
    .WIDTH(16)
  ) u_blk_count (
    .clk          (clk),
    .n_rst        (n_rst),
    .count_enable (handoff),
    .count_out    (blk_count)
  );

endmodule
